// File: rtl/sstv_pkg.sv
// Shared definitions for the SSTV pixel streamer.
//   ch_t            : Martin channel order (G, B, R)
//   fill_state_t    : framebuffer-to-line-buffer fill FSM states
//   stream_state_t  : line-buffer-to-consumer stream FSM states
//   expand_sample() : RGB565 field slice + bit-replicated widening to 8 bits
package sstv_pkg;

   typedef enum logic [1:0] {
      CH_G = 2'd0,
      CH_B = 2'd1,
      CH_R = 2'd2
   } ch_t;

   typedef enum logic {
      F_IDLE = 1'b0,
      F_RUN  = 1'b1
   } fill_state_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_LOAD  = 2'd2,
      S_READY = 2'd3
   } stream_state_t;

   // RGB565 field positions
   localparam int unsigned R_MSB = 15;
   localparam int unsigned R_LSB = 11;
   localparam int unsigned G_MSB = 10;
   localparam int unsigned G_LSB = 5;
   localparam int unsigned B_MSB = 4;
   localparam int unsigned B_LSB = 0;

   // Widen a channel by replicating its top bits into the new LSBs.
   function automatic logic [7:0] expand_sample(input ch_t ch, input logic [15:0] word);
      logic [4:0] r5;
      logic [5:0] g6;
      logic [4:0] b5;
      logic [7:0] res;
      r5  = word[R_MSB:R_LSB];
      g6  = word[G_MSB:G_LSB];
      b5  = word[B_MSB:B_LSB];
      res = '0;
      case (ch)
         CH_G:    res = {g6, g6[5:4]};
         CH_B:    res = {b5, b5[4:2]};
         CH_R:    res = {r5, r5[4:2]};
         default: res = '0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/line_buffer_dp.sv
// Simple dual-port line buffer RAM (two line banks back to back).
//   clk     : clock
//   wr_en   : write strobe (fill side)
//   wr_addr : write word address
//   wr_data : RGB565 word to store
//   rd_en   : read strobe (stream side)
//   rd_addr : read word address
//   rd_data : registered read data, valid the cycle after rd_en
module line_buffer_dp #(
   parameter int unsigned DEPTH = 640,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [15:0]   wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [15:0]   rd_data
);

   logic [15:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/sstv_pixel_streamer.sv
// Feeds 8-bit channel samples to the Martin M1 tone generator. Lines are
// fetched from a synchronous framebuffer into a ping-pong line buffer and
// presented per line in G, B, R order.
//   clk, rst      : clock, synchronous active-low reset
//   start         : 1-cycle pulse, (re)start a frame at line 0
//   send_trigger  : consumer request level; falling edge consumes a sample
//   px_odata      : current channel sample, valid while px_valid=1
//   px_valid      : px_odata holds the next unconsumed sample
//   fb_rd/fb_addr : framebuffer read strobe / word address (line*W + col)
//   fb_rdata      : framebuffer data, valid 1 cycle after fb_rd
//   frame_done    : sticky, whole frame streamed
//   underrun      : sticky, a sample was consumed while px_valid=0
module sstv_pixel_streamer
   import sstv_pkg::*;
#(
   parameter int unsigned SCANLINE_WIDTH = 320,
   parameter int unsigned SCANLINE_NUM   = 256,
   parameter int unsigned ADDR_W         = $clog2(SCANLINE_WIDTH * SCANLINE_NUM)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              send_trigger,
   output logic [7:0]        px_odata,
   output logic              px_valid,
   output logic              fb_rd,
   output logic [ADDR_W-1:0] fb_addr,
   input  logic [15:0]       fb_rdata,
   output logic              frame_done,
   output logic              underrun
);

   localparam int unsigned COL_W    = (SCANLINE_WIDTH > 1) ? $clog2(SCANLINE_WIDTH) : 1;
   localparam int unsigned LINE_W   = $clog2(SCANLINE_NUM + 1);
   localparam int unsigned LB_DEPTH = 2 * SCANLINE_WIDTH;
   localparam int unsigned LB_AW    = $clog2(LB_DEPTH);
   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(SCANLINE_WIDTH - 1);
   localparam logic [LINE_W-1:0] LINE_END  = LINE_W'(SCANLINE_NUM);
   localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(SCANLINE_NUM - 1);

   function automatic logic [LB_AW-1:0] lb_index(input logic bank, input logic [COL_W-1:0] col);
      return (bank ? LB_AW'(SCANLINE_WIDTH) : '0) + LB_AW'(col);
   endfunction

   // ---------------- fill side ----------------
   fill_state_t       fstate, fnext;
   logic [COL_W-1:0]  fill_col;
   logic [LINE_W-1:0] fill_line;
   logic              fill_bank;
   logic              wr_en_d, wr_bank_d, wr_last_d;
   logic [COL_W-1:0]  wr_col_d;
   logic [1:0]        full;

   // ---------------- stream side ----------------
   stream_state_t     sstate, snext;
   logic [COL_W-1:0]  str_col;
   ch_t               str_chan;
   logic [LINE_W-1:0] str_line;
   logic              str_bank;
   logic              load_d, trig_d, consume;
   logic              lb_rd, last_sample, advance, release_bank, underrun_hit;
   logic [15:0]       lb_q;

   assign consume = trig_d & ~send_trigger;

   line_buffer_dp #(
      .DEPTH (LB_DEPTH),
      .AW    (LB_AW)
   ) u_lb (
      .clk     (clk),
      .wr_en   (wr_en_d),
      .wr_addr (lb_index(wr_bank_d, wr_col_d)),
      .wr_data (fb_rdata),
      .rd_en   (lb_rd),
      .rd_addr (lb_index(str_bank, str_col)),
      .rd_data (lb_q)
   );

   // ---------------- fill FSM ----------------
   always_ff @(posedge clk) begin
      if (!rst) fstate <= F_IDLE;
      else      fstate <= fnext;
   end

   always_comb begin
      fnext = fstate;
      if (start) begin
         fnext = F_RUN;
      end else begin
         case (fstate)
            F_IDLE:  if (fill_line != LINE_END && !full[fill_bank]) fnext = F_RUN;
            F_RUN:   if (fill_col == COL_LAST) fnext = F_IDLE;
            default: fnext = F_IDLE;
         endcase
      end
   end

   always_comb begin
      fb_rd   = (fstate == F_RUN);
      fb_addr = '0;
      if (fstate == F_RUN)
         fb_addr = ADDR_W'(fill_line) * ADDR_W'(SCANLINE_WIDTH) + ADDR_W'(fill_col);
   end

   // fill_line resets to the end value so nothing is fetched before start.
   // Clearing wr_en_d on start drops any read still in flight.
   always_ff @(posedge clk) begin
      if (!rst) begin
         fill_col  <= '0;
         fill_line <= LINE_END;
         fill_bank <= 1'b0;
         wr_en_d   <= 1'b0;
         wr_bank_d <= 1'b0;
         wr_col_d  <= '0;
         wr_last_d <= 1'b0;
      end else if (start) begin
         fill_col  <= '0;
         fill_line <= '0;
         fill_bank <= 1'b0;
         wr_en_d   <= 1'b0;
      end else begin
         wr_en_d   <= (fstate == F_RUN);
         wr_bank_d <= fill_bank;
         wr_col_d  <= fill_col;
         wr_last_d <= (fill_col == COL_LAST);
         if (fstate == F_RUN) begin
            if (fill_col == COL_LAST) begin
               fill_col  <= '0;
               fill_line <= fill_line + LINE_W'(1);
               fill_bank <= ~fill_bank;
            end else begin
               fill_col <= fill_col + COL_W'(1);
            end
         end
      end
   end

   // Bank full flags: set by the last fill write, cleared when the stream
   // consumes the last sample of the bank. The two never target the same bank.
   always_ff @(posedge clk) begin
      if (!rst || start) begin
         full <= '0;
      end else begin
         if (release_bank)          full[str_bank]  <= 1'b0;
         if (wr_en_d && wr_last_d)  full[wr_bank_d] <= 1'b1;
      end
   end

   // ---------------- stream FSM ----------------
   always_ff @(posedge clk) begin
      if (!rst) sstate <= S_IDLE;
      else      sstate <= snext;
   end

   always_comb begin
      snext = sstate;
      if (start) begin
         snext = S_WAIT;
      end else begin
         case (sstate)
            S_IDLE:  snext = S_IDLE;
            S_WAIT:  if (full[str_bank]) snext = S_LOAD;
            S_LOAD:  if (load_d) snext = S_READY;
            S_READY: begin
               if (consume) begin
                  if (!last_sample)            snext = S_LOAD;
                  else if (str_line == LINE_LAST) snext = S_IDLE;
                  else                         snext = S_WAIT;
               end
            end
            default: snext = S_IDLE;
         endcase
      end
   end

   // The line-buffer read is launched from S_WAIT as soon as the bank is
   // full, so S_LOAD is entered with data already on its way; this keeps the
   // line hand-off at the same 2-cycle latency as an in-line advance.
   always_comb begin
      lb_rd        = (sstate == S_LOAD && !load_d) || (sstate == S_WAIT && full[str_bank]);
      last_sample  = (str_chan == CH_R) && (str_col == COL_LAST);
      advance      = (sstate == S_READY) && consume;
      release_bank = advance && last_sample;
      underrun_hit = consume && (sstate == S_WAIT || sstate == S_LOAD);
   end

   always_ff @(posedge clk) begin
      if (!rst) trig_d <= 1'b0;
      else if (start) trig_d <= 1'b0;
      else trig_d <= send_trigger;
   end

   always_ff @(posedge clk) begin
      if (!rst || start) begin
         str_col    <= '0;
         str_chan   <= CH_G;
         str_line   <= '0;
         str_bank   <= 1'b0;
         load_d     <= 1'b0;
         px_odata   <= '0;
         px_valid   <= 1'b0;
         frame_done <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         load_d <= lb_rd;
         if (sstate == S_LOAD && load_d) begin
            px_odata <= expand_sample(str_chan, lb_q);
            px_valid <= 1'b1;
         end
         if (underrun_hit) underrun <= 1'b1;
         if (advance) begin
            px_valid <= 1'b0;
            if (last_sample) begin
               str_col  <= '0;
               str_chan <= CH_G;
               str_bank <= ~str_bank;
               if (str_line == LINE_LAST) begin
                  frame_done <= 1'b1;
                  px_odata   <= '0;
                  str_line   <= '0;
               end else begin
                  str_line <= str_line + LINE_W'(1);
               end
            end else if (str_col == COL_LAST) begin
               str_col  <= '0;
               str_chan <= (str_chan == CH_G) ? CH_B : CH_R;
            end else begin
               str_col <= str_col + COL_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_sstv_pixel_streamer.sv
module tb_sstv_pixel_streamer;

   localparam int unsigned W  = 4;
   localparam int unsigned N  = 2;
   localparam int unsigned AW = 3;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           start = 1'b0;
   logic           send_trigger = 1'b0;
   logic [7:0]     px_odata;
   logic           px_valid;
   logic           fb_rd;
   logic [AW-1:0]  fb_addr;
   logic [15:0]    fb_rdata;
   logic           frame_done;
   logic           underrun;

   logic [15:0]    fb_mem [8];
   logic [7:0]     exp_q [$];
   int unsigned    checks = 0;
   int unsigned    passes = 0;
   logic           pv_prev = 1'b0;
   logic           seen_l1 = 1'b0;

   // Frame B framebuffer words and their hand-expanded samples (Martin order)
   logic [15:0] fb_b [8] = '{16'hF800, 16'h07E0, 16'h001F, 16'h8410,
                             16'hFFFF, 16'h0000, 16'h1234, 16'h0821};
   logic [7:0]  exp_b [24] = '{8'h00, 8'hFF, 8'h00, 8'h82,
                               8'h00, 8'h00, 8'hFF, 8'h84,
                               8'hFF, 8'h00, 8'h00, 8'h84,
                               8'hFF, 8'h00, 8'h45, 8'h04,
                               8'hFF, 8'h00, 8'hA5, 8'h08,
                               8'hFF, 8'h00, 8'h10, 8'h08};

   always #5 clk = ~clk;

   sstv_pixel_streamer #(
      .SCANLINE_WIDTH (W),
      .SCANLINE_NUM   (N),
      .ADDR_W         (AW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .send_trigger (send_trigger),
      .px_odata     (px_odata),
      .px_valid     (px_valid),
      .fb_rd        (fb_rd),
      .fb_addr      (fb_addr),
      .fb_rdata     (fb_rdata),
      .frame_done   (frame_done),
      .underrun     (underrun)
   );

   // Synchronous framebuffer model, 1-cycle read latency
   always @(posedge clk) if (fb_rd) fb_rdata <= fb_mem[fb_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Monitor: every newly presented sample is popped from the scoreboard
   always @(negedge clk) begin
      if (px_valid && !pv_prev) begin
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL sample_unexpected: got %0h, expected no sample", px_odata);
         end else begin
            chk("sample", 32'(px_odata), 32'(exp_q.pop_front()));
         end
      end
      pv_prev = px_valid;
      if (fb_rd && fb_addr == 3'd7) seen_l1 = 1'b1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic trig_pulse();
      send_trigger = 1'b1;
      tick();
      tick();
      send_trigger = 1'b0;
      tick();
   endtask

   task automatic wait_valid(input string name);
      int unsigned n;
      n = 0;
      while (!px_valid && n < 100) begin
         tick();
         n++;
      end
      if (!px_valid) begin
         checks++;
         $display("FAIL %s: px_valid 0 after %0d cycles, expected 1", name, n);
      end
   endtask

   task automatic consume();
      wait_valid("consume_timeout");
      trig_pulse();
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_px_odata"},   32'(px_odata),   32'h0);
      chk({tag, "_px_valid"},   32'(px_valid),   32'h0);
      chk({tag, "_fb_rd"},      32'(fb_rd),      32'h0);
      chk({tag, "_fb_addr"},    32'(fb_addr),    32'h0);
      chk({tag, "_frame_done"}, 32'(frame_done), 32'h0);
      chk({tag, "_underrun"},   32'(underrun),   32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      int unsigned lat;
      for (int i = 0; i < 8; i++) fb_mem[i] = 16'hFFFF;

      // Reset
      tick();
      tick();
      chk_reset_values("reset");
      rst = 1'b1;
      tick();

      // Frame A: all-white, fill reads addr 0..3 on consecutive cycles
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         chk("fill_rd_addr", 32'({fb_rd, fb_addr}), 32'({1'b1, 3'(i)}));
         tick();
      end
      for (int i = 0; i < 24; i++) exp_q.push_back(8'hFF);
      for (int i = 0; i < 24; i++) consume();
      chk("a_frame_done", 32'(frame_done), 32'h1);
      chk("a_px_valid",   32'(px_valid),   32'h0);
      chk("a_px_odata",   32'(px_odata),   32'h0);
      chk("a_underrun",   32'(underrun),   32'h0);
      trig_pulse();
      tick();
      tick();
      chk("a25_frame_done", 32'(frame_done), 32'h1);
      chk("a25_px_valid",   32'(px_valid),   32'h0);
      chk("a25_underrun",   32'(underrun),   32'h0);

      // Frame B: start while send_trigger is high must not consume
      for (int i = 0; i < 8; i++) fb_mem[i] = fb_b[i];
      seen_l1 = 1'b0;
      send_trigger = 1'b1;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      send_trigger = 1'b0;
      tick();
      chk("b_trig_discard_underrun", 32'(underrun), 32'h0);
      for (int i = 0; i < 24; i++) exp_q.push_back(exp_b[i]);
      // Consume before line 0 is loaded: underrun, no sample skipped
      send_trigger = 1'b1;
      tick();
      send_trigger = 1'b0;
      tick();
      chk("b_underrun_set", 32'(underrun), 32'h1);
      chk("b_underrun_px_valid", 32'(px_valid), 32'h0);
      for (int i = 0; i < 9; i++) consume();
      chk("b_line1_prefetched", 32'(seen_l1), 32'h1);
      for (int i = 0; i < 3; i++) consume();
      lat = 0;
      while (!px_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk("b_line_handoff_latency", lat, 32'd2);
      for (int i = 0; i < 12; i++) consume();
      chk("b_frame_done", 32'(frame_done), 32'h1);
      chk("b_underrun_sticky", 32'(underrun), 32'h1);

      // Frame C: abort mid line 0, then reset mid fill
      pulse_start();
      send_trigger = 1'b1;
      tick();
      send_trigger = 1'b0;
      tick();
      chk("c_underrun_set", 32'(underrun), 32'h1);
      chk("c_frame_done_cleared", 32'(frame_done), 32'h0);
      for (int i = 0; i < 6; i++) exp_q.push_back(exp_b[i]);
      for (int i = 0; i < 5; i++) consume();
      wait_valid("c_sixth_sample");
      pulse_start();
      chk("c_restart_addr", 32'({fb_rd, fb_addr}), 32'({1'b1, 3'd0}));
      chk("c_restart_px_valid", 32'(px_valid), 32'h0);
      chk("c_restart_underrun", 32'(underrun), 32'h0);
      chk("c_restart_frame_done", 32'(frame_done), 32'h0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk_reset_values("midfill_rst");
      rst = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      chk("post_rst_px_valid", 32'(px_valid), 32'h0);
      chk("post_rst_fb_rd",    32'(fb_rd),    32'h0);
      chk("scoreboard_empty",  32'(exp_q.size()), 32'h0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
